hazard_scoreboard: RTL

Parametrised successor to the fixed 2-port EX/MEM/WB forwarding unit. It tracks in-flight destination registers across DEPTH post-decode stages in a shift register and resolves a bypass source for NPORTS decode operands. It detects load-use hazards (stall plus bubble insertion), honours branch flush, and keeps saturating performance counters. It sits between decode and execute and drives the operand muxes.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/fwd_port_match.sv | 33 +++
 rtl/hazard_scoreboard.sv | 111 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard: entry attributes,
// forward-select encoding and stage indices.
package hazard_pkg;

    typedef struct packed {
        logic valid;
        logic we;
        logic is_load;
    } ent_flags_t;

    localparam int FWD_RF = 0;

    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_port_match.sv
// Priority search for one decode operand over the tracked stages; the youngest
// (lowest index) matching writer wins.
module fwd_port_match #(
    parameter int AW    = 5,
    parameter int DEPTH = 3,
    parameter int SELW  = 2,
    parameter int IW    = 2
) (
    input  logic                      used,
    input  logic [AW-1:0]             addr,
    input  logic [DEPTH-1:0]          ent_wr,
    input  logic [DEPTH-1:0]          ent_is_load,
    input  logic [DEPTH-1:0][AW-1:0]  ent_rd,
    output logic [SELW-1:0]           sel,
    output logic                      hit_is_load,
    output logic [IW-1:0]             hit_idx
);

    // Scan oldest to youngest so the youngest match is the last assignment.
    always_comb begin
        sel         = '0;
        hit_is_load = 1'b0;
        hit_idx     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (used && (addr != '0) && ent_wr[i] && (ent_rd[i] == addr)) begin
                sel         = SELW'(i + 1);
                hit_is_load = ent_is_load[i];
                hit_idx     = IW'(i);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destinations after decode, picks a bypass source per operand,
// raises load-use stalls and keeps saturating perf counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int DEPTH      = 3,
    parameter int NPORTS     = 2,
    parameter int LOAD_READY = 1,
    parameter int CNTW       = 32,
    localparam int AW   = $clog2(NREG),
    localparam int SELW = sel_width(DEPTH),
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic                     issue_we,
    input  logic                     issue_is_load,
    input  logic [AW-1:0]            issue_rd,
    input  logic                     flush,
    input  logic [NPORTS*AW-1:0]     rs_addr,
    input  logic [NPORTS-1:0]        rs_used,
    input  logic [NPORTS*XLEN-1:0]   rf_data,
    input  logic [DEPTH*XLEN-1:0]    stage_data,
    output logic [NPORTS*XLEN-1:0]   operand,
    output logic [NPORTS*SELW-1:0]   fwd_sel,
    output logic                     stall,
    output logic [CNTW-1:0]          stall_cycles,
    output logic [CNTW-1:0]          fwd_events
);

    ent_flags_t [DEPTH-1:0]          ents;
    logic [DEPTH-1:0][AW-1:0]        rd_pipe;
    logic [DEPTH-1:0]                ent_wr;
    logic [DEPTH-1:0]                ent_ld;

    logic [NPORTS-1:0][AW-1:0]       rs_arr;
    logic [NPORTS-1:0][XLEN-1:0]     rf_arr;
    logic [DEPTH-1:0][XLEN-1:0]      stage_arr;
    logic [NPORTS-1:0][XLEN-1:0]     op;
    logic [NPORTS-1:0][SELW-1:0]     sel;
    logic [NPORTS-1:0][IW-1:0]       hit_idx;
    logic [NPORTS-1:0]               hit_ld;
    logic [NPORTS-1:0]               hazard;
    logic [NPORTS-1:0]               fwd_hit;
    logic                            fwd_count;

    assign rs_arr    = rs_addr;
    assign rf_arr    = rf_data;
    assign stage_arr = stage_data;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_wr[i] = ents[i].valid & ents[i].we;
            ent_ld[i] = ents[i].is_load;
        end
    end

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        fwd_port_match #(
            .AW    (AW),
            .DEPTH (DEPTH),
            .SELW  (SELW),
            .IW    (IW)
        ) u_match (
            .used        (rs_used[p]),
            .addr        (rs_arr[p]),
            .ent_wr      (ent_wr),
            .ent_is_load (ent_ld),
            .ent_rd      (rd_pipe),
            .sel         (sel[p]),
            .hit_is_load (hit_ld[p]),
            .hit_idx     (hit_idx[p])
        );

        assign fwd_hit[p] = (sel[p] != SELW'(FWD_RF));
        // Load data only exists from LOAD_READY onward; earlier hits must wait.
        assign hazard[p]  = fwd_hit[p] & hit_ld[p] & (int'(hit_idx[p]) < LOAD_READY);
        assign op[p]      = fwd_hit[p] ? stage_arr[hit_idx[p]] : rf_arr[p];
    end

    assign operand   = op;
    assign fwd_sel   = sel;
    assign stall     = (|hazard) & issue_valid & ~flush;
    assign fwd_count = (|fwd_hit) & ~stall & ~flush & issue_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            ents         <= '0;
            rd_pipe      <= '0;
            stall_cycles <= '0;
            fwd_events   <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                ents[i]    <= ents[i-1];
                rd_pipe[i] <= rd_pipe[i-1];
            end
            ents[0].valid   <= issue_valid & ~flush & ~stall;
            ents[0].we      <= issue_we;
            ents[0].is_load <= issue_is_load;
            rd_pipe[0]      <= issue_rd;
            if (stall && !(&stall_cycles))
                stall_cycles <= stall_cycles + 1'b1;
            if (fwd_count && !(&fwd_events))
                fwd_events <= fwd_events + 1'b1;
        end
    end

endmodule
